sonar_scheduler: RTL and testbench

- Time-multiplexes N ultrasonic range sensors over one shared measurement engine, round-robin.
- Per slot: issues the trigger pulse, waits for the echo, measures echo-high width, compares it against a threshold, then enforces a guard interval before the next sensor fires.
- Sits between the sensor pins and the obstacle-decision logic; it replaces per-sensor free-running trigger counters with one sequenced schedule so sensors never fire together and cannot receive each other's echoes.

---
 rtl/sonar_pkg.sv | 23 ++
 rtl/echo_sync.sv | 31 +++
 rtl/sonar_scheduler.sv | 179 +++++++++++++++++
 tb/tb_sonar_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar scheduler.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    DONE,
    GUARD
  } state_t;

  localparam int unsigned DEF_TRIG_CYCLES  = 1200;
  localparam int unsigned DEF_ECHO_TIMEOUT = 3000000;
  localparam int unsigned DEF_MAX_ECHO     = 2500000;
  localparam int unsigned DEF_GUARD_CYCLES = 6500000;

  // Width of a sensor index; never zero so a single sensor still gets a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// N-bit two-flop synchroniser with per-bit rising/falling edge pulses.
module echo_sync #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise_c,
  output logic [W-1:0] fall_c
);

  logic [W-1:0] meta;
  logic [W-1:0] prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise_c = sync & ~prev;
  assign fall_c = ~sync & prev;

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler sharing one trigger/echo measurement engine across N ultrasonic sensors.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int unsigned N_SENSORS    = 2,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned TRIG_CYCLES  = DEF_TRIG_CYCLES,
  parameter int unsigned ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
  parameter int unsigned MAX_ECHO     = DEF_MAX_ECHO,
  parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [N_SENSORS-1:0]            sensor_mask,
  input  logic [CNT_W-1:0]                threshold,
  input  logic [N_SENSORS-1:0]            echo,
  output logic [N_SENSORS-1:0]            trig,
  output logic [N_SENSORS-1:0]            detected,
  output logic                            meas_valid,
  output logic [idx_w(N_SENSORS)-1:0]     meas_sensor,
  output logic [CNT_W-1:0]                meas_width,
  output logic                            meas_timeout,
  output logic                            busy
);

  localparam int unsigned IDX_W = idx_w(N_SENSORS);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc, width_c;
  logic [IDX_W-1:0]     idx, idx_n, sel_idx, base, cand;
  logic                 sel_found, fresh, done_n, tmo_c;
  logic [N_SENSORS-1:0] echo_s, echo_rise_c, echo_fall_c;
  logic                 sync_cur, rise_cur, fall_cur;

  echo_sync #(.W(N_SENSORS)) u_echo_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (echo),
    .sync   (echo_s),
    .rise_c (echo_rise_c),
    .fall_c (echo_fall_c)
  );

  assign sync_cur = echo_s[idx];
  assign rise_cur = echo_rise_c[idx];
  assign fall_cur = echo_fall_c[idx];
  assign cnt_inc  = cnt + CNT_W'(1);

  // Until the first slot the search starts just past the top index, so the lowest mask bit wins.
  assign base = fresh ? IDX_W'(N_SENSORS - 1) : idx;

  // Next masked-in sensor after base, wrapping; descending loop lets the nearest candidate win.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = int'(N_SENSORS); k >= 1; k--) begin
      cand = IDX_W'((int'(base) + k) % int'(N_SENSORS));
      if (sensor_mask[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    done_n  = 1'b0;
    tmo_c   = 1'b0;
    width_c = cnt;
    unique case (state)
      IDLE: begin
        if (enable && sel_found) begin
          state_n = TRIG;
          idx_n   = sel_idx;
          cnt_n   = '0;
        end
      end
      TRIG: begin
        if (cnt == CNT_W'(TRIG_CYCLES - 1)) begin
          state_n = WAIT_ECHO;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      WAIT_ECHO: begin
        // The edge cycle itself is already echo-high, so the width count restarts at one.
        if (rise_cur) begin
          state_n = MEASURE;
          cnt_n   = CNT_W'(1);
        end else if (cnt_inc == CNT_W'(ECHO_TIMEOUT)) begin
          state_n = DONE;
          done_n  = 1'b1;
          tmo_c   = 1'b1;
          width_c = '1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      MEASURE: begin
        if (fall_cur) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (sync_cur) begin
          if (cnt_inc == CNT_W'(MAX_ECHO)) begin
            state_n = DONE;
            done_n  = 1'b1;
            width_c = cnt_inc;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      DONE: begin
        state_n = GUARD;
        cnt_n   = '0;
      end
      GUARD: begin
        if (cnt_inc == CNT_W'(GUARD_CYCLES)) begin
          cnt_n = '0;
          if (enable && sel_found) begin
            state_n = TRIG;
            idx_n   = sel_idx;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      fresh <= 1'b1;
    end else begin
      cnt <= cnt_n;
      idx <= idx_n;
      if (state_n == TRIG) fresh <= 1'b0;
    end
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig         <= '0;
      detected     <= '0;
      meas_valid   <= 1'b0;
      meas_sensor  <= '0;
      meas_width   <= '0;
      meas_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      trig         <= (state_n == TRIG) ? (N_SENSORS'(1) << idx_n) : '0;
      busy         <= (state_n != IDLE);
      meas_valid   <= done_n;
      meas_timeout <= done_n & tmo_c;
      if (done_n) begin
        meas_sensor   <= idx;
        meas_width    <= width_c;
        detected[idx] <= !tmo_c && (width_c < threshold);
      end
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed scoreboard bench for sonar_scheduler with shortened timing.
module tb_sonar_scheduler;

  localparam int unsigned N     = 2;
  localparam int unsigned SW    = 1;
  localparam int unsigned CW    = 24;
  localparam int unsigned TRIGC = 10;
  localparam int unsigned TMO   = 100;
  localparam int unsigned MAXE  = 200;
  localparam int unsigned GRD   = 50;
  localparam logic [CW-1:0] THR = 24'd40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [N-1:0]  sensor_mask = 2'b11;
  logic [CW-1:0] threshold = THR;
  logic [N-1:0]  echo = '0;
  logic [N-1:0]  trig, detected;
  logic          meas_valid, meas_timeout, busy;
  logic [SW-1:0] meas_sensor;
  logic [CW-1:0] meas_width;

  sonar_scheduler #(
    .N_SENSORS(N), .CNT_W(CW), .TRIG_CYCLES(TRIGC),
    .ECHO_TIMEOUT(TMO), .MAX_ECHO(MAXE), .GUARD_CYCLES(GRD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensor_mask(sensor_mask),
    .threshold(threshold), .echo(echo), .trig(trig), .detected(detected),
    .meas_valid(meas_valid), .meas_sensor(meas_sensor), .meas_width(meas_width),
    .meas_timeout(meas_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sensor;
    logic [CW-1:0] width;
    logic          to;
  } exp_t;

  exp_t         q[$];
  logic [N-1:0] det_exp = '0;
  int checks = 0, failures = 0;
  int cyc = 0, n_valid = 0, exp_valid = 0, valid_cyc = 0;
  int rise_cyc[N] = '{default: 0};
  int run_len[N]  = '{default: 0};
  int last_len[N] = '{default: 0};
  int n_pulse[N]  = '{default: 0};
  logic [N-1:0] trig_prev = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Trigger bookkeeping and scoreboard pop on every completed slot.
  always @(negedge clk) begin
    exp_t e;
    if (reset) det_exp = '0;
    check("trig_onehot", 64'($countones(trig) <= 1), 64'd1);
    for (int i = 0; i < int'(N); i++) begin
      if (trig[i] && !trig_prev[i]) begin
        rise_cyc[i] = cyc;
        run_len[i]  = 1;
        n_pulse[i]++;
      end else if (trig[i]) begin
        run_len[i]++;
      end else if (trig_prev[i]) begin
        last_len[i] = run_len[i];
      end
    end
    trig_prev = trig;
    if (meas_valid) begin
      n_valid++;
      valid_cyc = cyc;
      check("valid_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        det_exp[e.sensor] = !e.to && (e.width < THR);
        check("meas_sensor", 64'(meas_sensor), 64'(e.sensor));
        check("meas_width", 64'(meas_width), 64'(e.width));
        check("meas_timeout", 64'(meas_timeout), 64'(e.to));
        check("detected", 64'(detected), 64'(det_exp));
      end
    end
  end

  task automatic run_slot(input int s, input int delay, input int len,
                          input bit stale, input bit stop_after, input bit gap);
    exp_t e;
    int   g;
    g = 0;
    while (!trig[s] && g < 300) begin step(); g++; end
    check("trig_rise_seen", 64'(trig[s]), 64'd1);
    if (gap) check("guard_gap", 64'(rise_cyc[s] - valid_cyc), 64'(GRD + 1));
    if (stale) echo[s] = 1'b1;
    g = 0;
    while (trig[s] && g < 50) begin step(); g++; end
    check("trig_len", 64'(last_len[s]), 64'(TRIGC));
    e.sensor = SW'(s);
    e.to     = stale || (len == 0);
    e.width  = e.to ? '1 : ((len > int'(MAXE)) ? CW'(MAXE) : CW'(len));
    q.push_back(e);
    exp_valid++;
    if (stop_after) enable = 1'b0;
    if (!e.to) begin
      repeat (delay) step();
      echo[s] = 1'b1;
      repeat (len) step();
      echo[s] = 1'b0;
    end
    g = 0;
    while (n_valid < exp_valid && g < 400) begin step(); g++; end
    check("valid_count", 64'(n_valid), 64'(exp_valid));
    if (stale) echo[s] = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 400) begin step(); g++; end
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int p0, seen_busy, g;
    repeat (3) step();
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_detected", 64'(detected), 64'd0);
    check("rst_width", 64'(meas_width), 64'd0);
    check("rst_flags", 64'({meas_valid, meas_timeout, meas_sensor, busy}), 64'd0);

    enable = 1'b1;
    reset  = 1'b0;
    run_slot(0, 20, 60, 1'b0, 1'b0, 1'b0);
    run_slot(1, 20, 25, 1'b0, 1'b0, 1'b1);
    run_slot(0, 20, 30, 1'b0, 1'b0, 1'b1);
    run_slot(1, 0, 0, 1'b1, 1'b0, 1'b1);
    run_slot(0, 15, 300, 1'b0, 1'b1, 1'b1);
    wait_idle();

    sensor_mask = 2'b10;
    enable      = 1'b1;
    p0          = n_pulse[0];
    run_slot(1, 20, 30, 1'b0, 1'b0, 1'b0);
    run_slot(1, 10, 50, 1'b0, 1'b1, 1'b1);
    check("mask_skips_s0", 64'(n_pulse[0]), 64'(p0));
    wait_idle();

    sensor_mask = '0;
    enable      = 1'b1;
    seen_busy   = 0;
    repeat (30) begin step(); if (busy || trig != '0) seen_busy++; end
    check("mask0_idle", 64'(seen_busy), 64'd0);

    sensor_mask = 2'b10;
    g = 0;
    while (!trig[1] && g < 50) begin step(); g++; end
    check("pre_reset_trig", 64'(trig), 64'b10);
    repeat (3) step();
    reset = 1'b1;
    #1;
    check("async_trig_drop", 64'(trig), 64'd0);
    check("rst_outputs", 64'({detected, meas_valid, meas_timeout, meas_sensor, busy}), 64'd0);
    check("rst_width2", 64'(meas_width), 64'd0);
    sensor_mask = 2'b11;
    repeat (2) step();
    reset = 1'b0;
    g = 0;
    while (trig == '0 && g < 50) begin step(); g++; end
    check("first_after_reset", 64'(trig), 64'b01);
    run_slot(0, 20, 30, 1'b0, 1'b1, 1'b0);
    wait_idle();

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
